// File: rtl/arith_pkg.sv
// arith_pkg: shared definitions for serial_arith_unit.
//   - X/Y operand pre-select codes (s[1:0] selects X, s[3:2] selects Y)
//   - FSM state encoding
// Optional feature macro used by the block: ARITH_FLAGS_EN (zero/ovf flags).
package arith_pkg;

  // X pre-select (s[1:0])
  localparam logic [1:0] XSEL_A     = 2'b00;  // A
  localparam logic [1:0] XSEL_NA    = 2'b01;  // ~A
  localparam logic [1:0] XSEL_LSR   = 2'b10;  // A >> 1, zero fill
  localparam logic [1:0] XSEL_LSL   = 2'b11;  // A << 1, zero fill

  // Y pre-select (s[3:2])
  localparam logic [1:0] YSEL_NBORA = 2'b00;  // ~B | A
  localparam logic [1:0] YSEL_B     = 2'b01;  // B
  localparam logic [1:0] YSEL_BORNA = 2'b10;  // B | ~A
  localparam logic [1:0] YSEL_ZERO  = 2'b11;  // 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_arith_unit_if.sv
// serial_arith_unit_if: request/response bundle of serial_arith_unit.
//   Request : in_valid, in_ready, a_in, b_in, s[3:0], csel
//   Response: out_valid, out_ready, result, c_out
//             zero, ovf (only when ARITH_FLAGS_EN is defined)
//   master = producer of requests / consumer of results (testbench, datapath)
//   slave  = the arithmetic unit
interface serial_arith_unit_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       s;
  logic             csel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
`ifdef ARITH_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a_in, b_in, s, csel, out_ready,
    input  in_ready, out_valid, result, c_out, zero, ovf
  );
  modport slave (
    input  in_valid, a_in, b_in, s, csel, out_ready,
    output in_ready, out_valid, result, c_out, zero, ovf
  );
`else
  modport master (
    output in_valid, a_in, b_in, s, csel, out_ready,
    input  in_ready, out_valid, result, c_out
  );
  modport slave (
    input  in_valid, a_in, b_in, s, csel, out_ready,
    output in_ready, out_valid, result, c_out
  );
`endif
endinterface

// File: rtl/serial_arith_unit_slice_adder.sv
// slice_adder: combinational SLICE_W-bit adder.
//   i_x, i_y   : slice operands
//   i_cin      : carry in
//   o_sum      : slice sum
//   o_cout     : carry out of the slice MSB
//   o_msb_cin  : carry into the slice MSB (used for signed overflow)
module slice_adder #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] i_x,
  input  logic [SLICE_W-1:0] i_y,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout,
  output logic               o_msb_cin
);
  logic [SLICE_W:0] w_full;

  assign w_full = {1'b0, i_x} + {1'b0, i_y} + {{SLICE_W{1'b0}}, i_cin};
  assign o_sum  = w_full[SLICE_W-1:0];
  assign o_cout = w_full[SLICE_W];
  // sum_msb = x ^ y ^ c_in_msb, so the MSB carry-in falls out of the sum bit
  assign o_msb_cin = i_x[SLICE_W-1] ^ i_y[SLICE_W-1] ^ w_full[SLICE_W-1];
endmodule

// File: rtl/serial_arith_unit.sv
// serial_arith_unit: slice-sequential X + Y + csel over WIDTH bits, SLICE_W
// bits per clock (N = WIDTH/SLICE_W RUN cycles per operation).
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : serial_arith_unit_if.slave
//              in_valid/in_ready handshake with a_in, b_in, s, csel
//              out_valid/out_ready handshake with result, c_out
//              zero, ovf when ARITH_FLAGS_EN is defined
// Flow: IDLE accepts and captures X/Y/csel, RUN adds one slice per edge
// with the carry held in r_carry, DONE presents the result until out_ready.
module serial_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_arith_unit_if.slave bus
);
  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("serial_arith_unit: WIDTH must be a multiple of SLICE_W");
    end
  endgenerate

  state_t              r_state;
  logic [WIDTH-1:0]    r_x;
  logic [WIDTH-1:0]    r_y;
  logic [WIDTH-1:0]    r_result;
  logic                r_carry;
  logic [CW-1:0]       r_cnt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_c_out;
`ifdef ARITH_FLAGS_EN
  logic                r_zero;
  logic                r_ovf;
`endif

  logic [WIDTH-1:0]    w_x;
  logic [WIDTH-1:0]    w_y;
  logic [SLICE_W-1:0]  w_xs;
  logic [SLICE_W-1:0]  w_ys;
  logic [SLICE_W-1:0]  w_sum;
  logic                w_cout;
  logic                w_msb_cin;
  logic [WIDTH-1:0]    w_res_nxt;
  logic                w_last;

  // Operand pre-select, evaluated from the live inputs and captured on accept
  always_comb begin
    w_x = bus.a_in;
    case (bus.s[1:0])
      XSEL_A:   w_x = bus.a_in;
      XSEL_NA:  w_x = ~bus.a_in;
      XSEL_LSR: w_x = bus.a_in >> 1;
      default:  w_x = bus.a_in << 1;
    endcase
  end

  always_comb begin
    w_y = '0;
    case (bus.s[3:2])
      YSEL_NBORA: w_y = ~bus.b_in | bus.a_in;
      YSEL_B:     w_y = bus.b_in;
      YSEL_BORNA: w_y = bus.b_in | ~bus.a_in;
      default:    w_y = '0;
    endcase
  end

  assign w_xs   = r_x[int'(r_cnt)*SLICE_W +: SLICE_W];
  assign w_ys   = r_y[int'(r_cnt)*SLICE_W +: SLICE_W];
  assign w_last = (r_cnt == CW'(N-1));

  slice_adder #(.SLICE_W(SLICE_W)) u_slice (
    .i_x       (w_xs),
    .i_y       (w_ys),
    .i_cin     (r_carry),
    .o_sum     (w_sum),
    .o_cout    (w_cout),
    .o_msb_cin (w_msb_cin)
  );

  // Result with the current slice merged in; on the last slice this is the
  // final value, so the zero flag can be registered alongside it.
  always_comb begin
    w_res_nxt = r_result;
    w_res_nxt[int'(r_cnt)*SLICE_W +: SLICE_W] = w_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_c_out     <= 1'b0;
`ifdef ARITH_FLAGS_EN
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_x        <= w_x;
            r_y        <= w_y;
            r_carry    <= bus.csel;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_result <= w_res_nxt;
          r_carry  <= w_cout;
          if (w_last) begin
            r_cnt       <= '0;
            r_c_out     <= w_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
`ifdef ARITH_FLAGS_EN
            r_zero      <= (w_res_nxt == '0);
            r_ovf       <= w_msb_cin ^ w_cout;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.c_out     = r_c_out;
`ifdef ARITH_FLAGS_EN
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
`endif

endmodule
